// File: rtl/mm_uart.sv
// Memory-mapped UART with TX/RX FIFOs, sticky error flags and a level interrupt.
// Optional parity support is built when MM_UART_PARITY_EN is defined.
module mm_uart #(
   parameter int          DATA_BITS  = 8,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] DIV_RESET  = 16'd434
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [5:0]  addr_i,
   input  logic        write_i,
   input  logic        read_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        uart_tx_o,
   input  logic        uart_rx_i,
   output logic        reset_o,
   output logic        irq_o
);
   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH    = (AW+1)'(FIFO_DEPTH);
   localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS-1);
`ifdef MM_UART_PARITY_EN
   localparam logic [6:0]  CTRL_MASK = 7'h7F;
`else
   localparam logic [6:0]  CTRL_MASK = 7'h1F;
`endif

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
   logic [DATA_BITS-1:0] r_rx_mem [FIFO_DEPTH];
   logic [AW-1:0]  r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
   logic [AW:0]    r_tx_cnt, r_rx_cnt;
   logic [6:0]     r_ctrl;
   logic [15:0]    r_div;
   logic [31:0]    r_data_o;
   logic           r_irq, r_rx_ovf, r_frame_err, r_par_err, r_tx_ovf;
   state_t         r_tx_state, r_rx_state;
   logic [15:0]    r_tx_tmr, r_tx_per, r_rx_tmr, r_rx_per;
   logic [2:0]     r_tx_bit, r_rx_bit;
   logic [DATA_BITS-1:0] r_tx_sh, r_rx_sh, r_rx_char;
   logic           r_tx_par, r_tx_par_en, r_txd;
   logic           r_rx_s1, r_rx_s2, r_rx_s3, r_rx_par_en, r_rx_par_odd;
   logic           r_rx_push, r_rx_ferr, r_rx_perr;

   logic        w_sel_data, w_sel_stat, w_sel_ctrl, w_sel_div;
   logic        w_tx_full, w_rx_full, w_tx_push, w_tx_load, w_tx_tick, w_tx_idle;
   logic        w_rx_pop, w_rx_wr, w_rx_tick, w_rx_half, w_rx_src;
   logic [15:0] w_per, w_status;
   logic [8:0]  w_rx_cnt9;
   logic [3:0]  w_clr;
   logic [DATA_BITS-1:0] w_tx_head;
   logic        w_unused_ok;

   assign w_sel_data = (addr_i == 6'd0);
   assign w_sel_stat = (addr_i == 6'd1);
   assign w_sel_ctrl = (addr_i == 6'd2);
   assign w_sel_div  = (addr_i == 6'd3);
   assign w_per      = (r_div < 16'd2) ? 16'd2 : r_div;
   assign w_tx_full  = (r_tx_cnt == DEPTH);
   assign w_rx_full  = (r_rx_cnt == DEPTH);
   assign w_tx_push  = write_i && w_sel_data && !w_tx_full;
   assign w_tx_tick  = (r_tx_tmr == r_tx_per - 16'd1);
   assign w_tx_load  = (r_tx_cnt != '0) &&
                       ((r_tx_state == S_IDLE) || (r_tx_state == S_STOP && w_tx_tick));
   assign w_tx_idle  = (r_tx_cnt == '0) && (r_tx_state == S_IDLE);
   assign w_tx_head  = r_tx_mem[r_tx_rp];
   assign w_rx_pop   = read_i && w_sel_data && (r_rx_cnt != '0);
   assign w_rx_wr    = r_rx_push && (!w_rx_full || w_rx_pop);
   assign w_rx_tick  = (r_rx_tmr == r_rx_per - 16'd1);
   assign w_rx_half  = (r_rx_tmr == {1'b0, r_rx_per[15:1]});
   assign w_rx_src   = r_ctrl[4] ? r_txd : uart_rx_i;
   assign w_rx_cnt9  = 9'(r_rx_cnt);
   assign w_clr      = (write_i && w_sel_stat) ? data_i[6:3] : 4'd0;
   assign w_status   = {(w_rx_cnt9[8] ? 8'hFF : w_rx_cnt9[7:0]), 1'b0, r_tx_ovf, r_par_err,
                        r_frame_err, r_rx_ovf, w_tx_idle, w_tx_full, (r_rx_cnt != '0)};
   assign w_unused_ok = &{1'b0, data_i[31:16]};

   assign uart_tx_o = r_ctrl[4] | r_txd;
   assign data_o    = r_data_o;
   assign reset_o   = r_ctrl[0];
   assign irq_o     = r_irq;

   always_ff @(posedge clk_i) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= data_i[DATA_BITS-1:0];
      if (w_rx_wr)   r_rx_mem[r_rx_wp] <= r_rx_char;
   end

   // FIFO bookkeeping; pointers wrap naturally since depth is a power of two.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0;
         r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
         if (w_tx_load) r_tx_rp <= r_tx_rp + 1'b1;
         if (w_tx_push && !w_tx_load)      r_tx_cnt <= r_tx_cnt + 1'b1;
         else if (!w_tx_push && w_tx_load) r_tx_cnt <= r_tx_cnt - 1'b1;
         if (w_rx_wr)  r_rx_wp <= r_rx_wp + 1'b1;
         if (w_rx_pop) r_rx_rp <= r_rx_rp + 1'b1;
         if (w_rx_wr && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
         else if (!w_rx_wr && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_tx_state <= S_IDLE; r_tx_tmr <= '0; r_tx_per <= 16'd2; r_tx_bit <= '0;
         r_tx_sh <= '0; r_tx_par <= 1'b0; r_tx_par_en <= 1'b0; r_txd <= 1'b1;
      end else begin
         r_tx_tmr <= r_tx_tmr + 16'd1;
         if (w_tx_load) begin
            r_tx_state  <= S_START;
            r_tx_tmr    <= '0;
            r_tx_per    <= w_per;
            r_tx_sh     <= w_tx_head;
            r_tx_par    <= (^w_tx_head) ^ r_ctrl[6];
            r_tx_par_en <= r_ctrl[5];
            r_txd       <= 1'b0;
         end else if (r_tx_state != S_IDLE && w_tx_tick) begin
            r_tx_tmr <= '0;
            case (r_tx_state)
               S_START: begin r_tx_state <= S_DATA; r_tx_bit <= '0; r_txd <= r_tx_sh[0]; end
               S_DATA: begin
                  if (r_tx_bit == LAST_BIT) begin
                     r_tx_state <= r_tx_par_en ? S_PARITY : S_STOP;
                     r_txd      <= r_tx_par_en ? r_tx_par : 1'b1;
                  end else begin
                     r_tx_bit <= r_tx_bit + 3'd1;
                     r_tx_sh  <= r_tx_sh >> 1;
                     r_txd    <= r_tx_sh[1];
                  end
               end
               S_PARITY: begin r_tx_state <= S_STOP; r_txd <= 1'b1; end
               default:  begin r_tx_state <= S_IDLE; r_txd <= 1'b1; end
            endcase
         end
      end
   end

   // Start bit is checked at half a period, then every later bit one full period on.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_s3 <= 1'b1;
         r_rx_state <= S_IDLE; r_rx_tmr <= '0; r_rx_per <= 16'd2; r_rx_bit <= '0;
         r_rx_sh <= '0; r_rx_char <= '0; r_rx_par_en <= 1'b0; r_rx_par_odd <= 1'b0;
         r_rx_push <= 1'b0; r_rx_ferr <= 1'b0; r_rx_perr <= 1'b0;
      end else begin
         r_rx_s1   <= w_rx_src;
         r_rx_s2   <= r_rx_s1;
         r_rx_s3   <= r_rx_s2;
         r_rx_push <= 1'b0;
         r_rx_ferr <= 1'b0;
         r_rx_perr <= 1'b0;
         r_rx_tmr  <= r_rx_tmr + 16'd1;
         case (r_rx_state)
            S_IDLE: if (r_rx_s3 && !r_rx_s2) begin
               r_rx_state   <= S_START;
               r_rx_tmr     <= '0;
               r_rx_per     <= w_per;
               r_rx_par_en  <= r_ctrl[5];
               r_rx_par_odd <= r_ctrl[6];
            end
            S_START: if (w_rx_half) begin
               r_rx_tmr   <= '0;
               r_rx_bit   <= '0;
               r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: if (w_rx_tick) begin
               r_rx_tmr <= '0;
               r_rx_sh  <= {r_rx_s2, r_rx_sh[DATA_BITS-1:1]};
               if (r_rx_bit == LAST_BIT) r_rx_state <= r_rx_par_en ? S_PARITY : S_STOP;
               else                      r_rx_bit   <= r_rx_bit + 3'd1;
            end
            S_PARITY: if (w_rx_tick) begin
               r_rx_tmr   <= '0;
               r_rx_perr  <= (r_rx_s2 != ((^r_rx_sh) ^ r_rx_par_odd));
               r_rx_state <= S_STOP;
            end
            default: if (w_rx_tick) begin
               r_rx_tmr   <= '0;
               r_rx_state <= S_IDLE;
               r_rx_push  <= r_rx_s2;
               r_rx_ferr  <= !r_rx_s2;
               r_rx_char  <= r_rx_sh;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_ctrl <= '0; r_div <= DIV_RESET; r_data_o <= '0; r_irq <= 1'b0;
         r_rx_ovf <= 1'b0; r_frame_err <= 1'b0; r_par_err <= 1'b0; r_tx_ovf <= 1'b0;
      end else begin
         if (write_i && w_sel_ctrl) r_ctrl <= data_i[6:0] & CTRL_MASK;
         if (write_i && w_sel_div)  r_div  <= data_i[15:0];
         r_rx_ovf    <= (r_rx_ovf & ~w_clr[0]) | (r_rx_push && w_rx_full && !w_rx_pop);
         r_frame_err <= (r_frame_err & ~w_clr[1]) | r_rx_ferr;
         r_par_err   <= (r_par_err & ~w_clr[2]) | r_rx_perr;
         r_tx_ovf    <= (r_tx_ovf & ~w_clr[3]) | (write_i && w_sel_data && w_tx_full);
         if (read_i) begin
            case (addr_i)
               6'd0:    r_data_o <= w_rx_pop ? 32'(r_rx_mem[r_rx_rp]) : 32'd0;
               6'd1:    r_data_o <= {16'd0, w_status};
               6'd2:    r_data_o <= {25'd0, r_ctrl};
               6'd3:    r_data_o <= {16'd0, r_div};
               default: r_data_o <= 32'd0;
            endcase
         end
         r_irq <= (r_ctrl[1] & w_status[0]) | (r_ctrl[2] & w_tx_idle) |
                  (r_ctrl[3] & (|w_status[6:3]));
      end
   end
endmodule

// File: tb/tb_mm_uart.sv
// Directed testbench for mm_uart: bus access, TX waveform, loopback, FIFO limits, errors, reset.
module tb_mm_uart;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [5:0]  addr = '0;
   logic        wr = 1'b0;
   logic        rd = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] data_o;
   logic        uart_tx_o;
   logic        uart_rx_i = 1'b1;
   logic        reset_o;
   logic        irq_o;
   int          total = 0;
   int          bad = 0;

   mm_uart dut (
      .clk_i(clk), .reset_i(rst), .addr_i(addr), .write_i(wr), .read_i(rd),
      .data_i(wdata), .data_o(data_o), .uart_tx_o(uart_tx_o), .uart_rx_i(uart_rx_i),
      .reset_o(reset_o), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      addr = a; wdata = d; wr = 1'b1;
      @(posedge clk); #1;
      wr = 1'b0;
      $display("bus wr addr=%0d data=0x%08h", a, d);
   endtask

   task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
      @(posedge clk); #1;
      addr = a; rd = 1'b1;
      @(posedge clk); #1;
      rd = 1'b0;
      d = data_o;
      $display("bus rd addr=%0d data=0x%08h", a, d);
   endtask

   task automatic rx_bit(input logic b);
      uart_rx_i = b;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] ch, input logic par_on, input logic par_bit,
                             input logic stop_bit);
      rx_bit(1'b0);
      for (int i = 0; i < 8; i++) rx_bit(ch[i]);
      if (par_on) rx_bit(par_bit);
      rx_bit(stop_bit);
      rx_bit(1'b1);
      $display("rx frame char=0x%02h stop=%0b", ch, stop_bit);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      do_reset();
      total++; if (uart_tx_o !== 1'b1) begin bad++; $display("FAIL reset_tx: got=%0b want=1", uart_tx_o); end
      total++; if (reset_o !== 1'b0) begin bad++; $display("FAIL reset_reseto: got=%0b want=0", reset_o); end
      total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq: got=%0b want=0", irq_o); end
      total++; if (data_o !== 32'd0) begin bad++; $display("FAIL reset_datao: got=0x%0h want=0x0", data_o); end
      bus_read(6'd1, d);
      total++; if (d !== 32'h4) begin bad++; $display("FAIL reset_status: got=0x%0h want=0x4", d); end
      bus_read(6'd3, d);
      total++; if (d !== 32'd434) begin bad++; $display("FAIL reset_div: got=0x%0h want=0x1b2", d); end
      bus_read(6'd2, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_ctrl: got=0x%0h want=0x0", d); end
      bus_read(6'd0, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_data_empty: got=0x%0h want=0x0", d); end
      bus_read(6'd9, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL unmapped_read: got=0x%0h want=0x0", d); end
   endtask

   task automatic test_ctrl();
      logic [31:0] d;
      logic [31:0] want;
`ifdef MM_UART_PARITY_EN
      want = 32'h7F;
`else
      want = 32'h1F;
`endif
      bus_write(6'd2, 32'hFF);
      bus_read(6'd2, d);
      total++; if (d !== want) begin bad++; $display("FAIL ctrl_mask: got=0x%0h want=0x%0h", d, want); end
      total++; if (reset_o !== 1'b1) begin bad++; $display("FAIL ctrl_reseto: got=%0b want=1", reset_o); end
      total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL txe_irq: got=%0b want=1", irq_o); end
      do_reset();
   endtask

   task automatic test_tx_frame();
      logic [31:0] d;
      logic [9:0]  exp_bits;
      exp_bits = {1'b1, 8'h55, 1'b0};
      bus_write(6'd3, 32'd4);
      bus_write(6'd0, 32'h55);
      repeat (3) @(posedge clk); #1;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) begin repeat (4) @(posedge clk); #1; end
         total++;
         if (uart_tx_o !== exp_bits[k]) begin
            bad++; $display("FAIL tx_bit%0d: got=%0b want=%0b", k, uart_tx_o, exp_bits[k]);
         end
      end
      bus_read(6'd1, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL tx_busy_in_stop: got=0x%0h want=0x0", d); end
      bus_read(6'd1, d);
      total++; if (d !== 32'h4) begin bad++; $display("FAIL tx_idle_after: got=0x%0h want=0x4", d); end
   endtask

   task automatic test_loopback();
      logic [31:0] d;
      do_reset();
      bus_write(6'd3, 32'd8);
      bus_write(6'd2, 32'h12);
      bus_write(6'd0, 32'hA3);
      repeat (19) @(posedge clk); #1;
      total++; if (uart_tx_o !== 1'b1) begin bad++; $display("FAIL lb_tx_held: got=%0b want=1", uart_tx_o); end
      total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL lb_irq_early: got=%0b want=0", irq_o); end
      repeat (81) @(posedge clk); #1;
      total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL lb_irq: got=%0b want=1", irq_o); end
      bus_read(6'd0, d);
      total++; if (d !== 32'hA3) begin bad++; $display("FAIL lb_data: got=0x%0h want=0xa3", d); end
      repeat (2) @(posedge clk); #1;
      total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL lb_irq_drop: got=%0b want=0", irq_o); end
      total++; if (data_o !== 32'hA3) begin bad++; $display("FAIL lb_data_hold: got=0x%0h want=0xa3", data_o); end
      bus_read(6'd0, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL lb_empty_read: got=0x%0h want=0x0", d); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      bus_write(6'd0, 32'h3C);
      bus_write(6'd0, 32'hC5);
      repeat (158) @(posedge clk);
      bus_read(6'd1, d);
      total++; if (d[2] !== 1'b1) begin bad++; $display("FAIL b2b_chain_idle: got=%0b want=1", d[2]); end
      repeat (100) @(posedge clk);
      bus_read(6'd1, d);
      total++; if (d !== 32'h0205) begin bad++; $display("FAIL b2b_status: got=0x%0h want=0x205", d); end
      bus_read(6'd0, d);
      total++; if (d !== 32'h3C) begin bad++; $display("FAIL b2b_first: got=0x%0h want=0x3c", d); end
      bus_read(6'd0, d);
      total++; if (d !== 32'hC5) begin bad++; $display("FAIL b2b_second: got=0x%0h want=0xc5", d); end
   endtask

   task automatic test_rx_overflow();
      logic [31:0] d;
      do_reset();
      bus_write(6'd3, 32'd8);
      for (int i = 0; i < 17; i++) send_frame(8'(i * 17 + 3), 1'b0, 1'b0, 1'b1);
      repeat (10) @(posedge clk);
      bus_read(6'd1, d);
      total++; if (d !== 32'h100D) begin bad++; $display("FAIL rxovf_status: got=0x%0h want=0x100d", d); end
      bus_write(6'd1, 32'h08);
      bus_read(6'd1, d);
      total++; if (d !== 32'h1005) begin bad++; $display("FAIL rxovf_clear: got=0x%0h want=0x1005", d); end
      bus_read(6'd0, d);
      total++; if (d !== 32'h03) begin bad++; $display("FAIL rxovf_oldest: got=0x%0h want=0x3", d); end
      bus_read(6'd1, d);
      total++; if (d !== 32'h0F05) begin bad++; $display("FAIL rxovf_fill: got=0x%0h want=0xf05", d); end
   endtask

   task automatic test_frame_err();
      logic [31:0] d;
      do_reset();
      bus_write(6'd3, 32'd8);
      bus_write(6'd2, 32'h08);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      bus_read(6'd1, d);
      total++; if (d !== 32'h0014) begin bad++; $display("FAIL ferr_status: got=0x%0h want=0x14", d); end
      total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL ferr_irq: got=%0b want=1", irq_o); end
      bus_write(6'd1, 32'h10);
      repeat (2) @(posedge clk); #1;
      total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL ferr_irq_clear: got=%0b want=0", irq_o); end
      bus_read(6'd1, d);
      total++; if (d !== 32'h0004) begin bad++; $display("FAIL ferr_cleared: got=0x%0h want=0x4", d); end
   endtask

   task automatic test_tx_overflow_reset();
      logic [31:0] d;
      do_reset();
      bus_write(6'd3, 32'd100);
      for (int i = 0; i < 18; i++) bus_write(6'd0, 32'(i + 1));
      bus_read(6'd1, d);
      total++; if (d !== 32'h0042) begin bad++; $display("FAIL txovf_status: got=0x%0h want=0x42", d); end
      total++; if (uart_tx_o !== 1'b0) begin bad++; $display("FAIL txovf_in_start: got=%0b want=0", uart_tx_o); end
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      total++; if (uart_tx_o !== 1'b1) begin bad++; $display("FAIL async_reset_tx: got=%0b want=1", uart_tx_o); end
      total++; if (data_o !== 32'd0) begin bad++; $display("FAIL async_reset_datao: got=0x%0h want=0x0", data_o); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      bus_read(6'd1, d);
      total++; if (d !== 32'h0004) begin bad++; $display("FAIL post_reset_status: got=0x%0h want=0x4", d); end
      bus_read(6'd3, d);
      total++; if (d !== 32'd434) begin bad++; $display("FAIL post_reset_div: got=0x%0h want=0x1b2", d); end
   endtask

`ifdef MM_UART_PARITY_EN
   task automatic test_parity();
      logic [31:0] d;
      do_reset();
      bus_write(6'd3, 32'd8);
      bus_write(6'd2, 32'h20);
      send_frame(8'h07, 1'b1, 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      bus_read(6'd1, d);
      total++; if (d !== 32'h0125) begin bad++; $display("FAIL par_status: got=0x%0h want=0x125", d); end
      bus_read(6'd0, d);
      total++; if (d !== 32'h07) begin bad++; $display("FAIL par_data: got=0x%0h want=0x7", d); end
   endtask
`endif

   initial begin
      test_reset();
      test_ctrl();
      test_tx_frame();
      test_loopback();
      test_back_to_back();
      test_rx_overflow();
      test_frame_err();
      test_tx_overflow_reset();
`ifdef MM_UART_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mm_uart.md
MM_UART -- requirements
Module: mm_uart

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning character width; legal 5..8.
REQ-002 Parameter FIFO_DEPTH, default 16, meaning entries per TX and RX FIFO; power of two, 2..256.
REQ-003 Parameter DIV_RESET, default 16'd434, meaning reset value of the baud divisor in clk_i cycles per bit.
REQ-004 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i  input  1  single clock for bus, UART and FIFOs.
- reset_i  input  1  asynchronous, active-high reset.
- addr_i  input  6  word address.
- write_i  input  1  single-cycle write strobe.
- read_i  input  1  single-cycle read strobe.
- data_i  input  32  write data.
- data_o  output  32  registered read data.
- uart_tx_o  output  1  serial out, idle high.
- uart_rx_i  input  1  serial in, asynchronous.
- reset_o  output  1  support-CPU reset, from CTRL[0].
- irq_o  output  1  level interrupt.

Function
REQ-005 Register map SHALL be: addr 0 DATA, 1 STATUS, 2 CTRL, 3 DIV; other addresses read 0 and ignore writes.
REQ-006 Write DATA SHALL push data_i[DATA_BITS-1:0] into the TX FIFO; when the FIFO is full, the write is dropped and STATUS[6] tx_ovf is set.
REQ-007 Read DATA SHALL pop the RX FIFO and return the head character zero-extended; when the FIFO is empty, it returns 0 with no pop.
REQ-008 data_o SHALL be valid the cycle after read_i and hold until the next read.
REQ-009 STATUS bit map SHALL be:
- [0] rx_avail, [1] tx_full, [2] tx_idle (FIFO empty and shifter idle).
- [3] rx_ovf, [4] frame_err, [5] parity_err, [6] tx_ovf.
- [15:8] RX fill count, saturating at 255.
REQ-010 STATUS bits 3..6 SHALL be sticky, cleared by writing 1 to the bit in STATUS.
REQ-011 CTRL SHALL have bit map:
- [0] drives reset_o.
- [1] rx_irq_en, [2] txe_irq_en, [3] err_irq_en.
- [4] loopback: RX input taken from uart_tx_o, uart_tx_o held high.
REQ-012 irq_o SHALL be (rx_irq_en & rx_avail) | (txe_irq_en & tx_idle) | (err_irq_en & any of STATUS[3:6]), registered.
REQ-013 DIV[15:0] SHALL give the bit period in clk_i cycles; a write takes effect at the next frame start, and a value of 0 or 1 is treated as 2.
REQ-014 TX state machine SHALL cycle IDLE -> START -> DATA (LSB first) -> [PARITY] -> STOP -> IDLE, each state lasting one bit period.
REQ-015 TX SHALL leave IDLE the cycle after the FIFO becomes non-empty and chain back-to-back frames with no idle bit.
REQ-016 RX input SHALL pass a 2-flop synchroniser; a falling edge in IDLE starts the bit counter.
REQ-017 RX SHALL sample each bit at DIV/2 cycles after its nominal edge; a start bit sampled high aborts to IDLE silently.
REQ-018 RX stop bit sampled low SHALL set frame_err and discard the character.
REQ-019 An RX push into a full FIFO SHALL drop the character and set rx_ovf, except when a pop occurs in the same cycle, in which case the push succeeds.
REQ-020 Simultaneous push and pop on either FIFO SHALL keep the count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-021 reset_i SHALL force immediately, regardless of any frame in progress:
- uart_tx_o=1, reset_o=0, irq_o=0, data_o=0.
- FIFOs empty, all flags 0, CTRL=0, DIV=DIV_RESET, both state machines IDLE.

Configuration
REQ-022 With macro MM_UART_PARITY_EN defined:
- CTRL[5] enables an even-parity bit between data and stop; CTRL[6]=1 selects odd parity.
- An RX parity mismatch sets parity_err and still stores the character.
- Without the macro, no parity bit is sent or checked, CTRL[6:5] read 0, and STATUS[5] is tied 0.

Verification
REQ-023 Reset, write DIV=4, write DATA=0x55 -> uart_tx_o shows start 0, bits 1,0,1,0,1,0,1,0, stop 1, each 4 clocks; tx_idle=1 after 40 clocks.
REQ-024 CTRL=0x12 (loopback, rx_irq), write 0xA3 -> irq_o=1 after frame; read DATA -> data_o=0x000000A3 next cycle; irq_o drops.
REQ-025 Drive FIFO_DEPTH+1 RX frames without reads -> STATUS[8+:8]=FIFO_DEPTH, rx_ovf=1; write STATUS=0x08 -> rx_ovf=0.
REQ-026 RX frame with stop bit 0 -> frame_err=1, rx_avail stays 0.
REQ-027 Assert reset_i mid-TX-frame -> uart_tx_o=1 the same cycle, tx_idle=1, FIFO count 0.
REQ-028 MM_UART_PARITY_EN, CTRL[5]=1, receive 0x07 with wrong parity -> parity_err=1, DATA reads 0x07.
